// File: rtl/ex_alu1_seq_if.sv
// Handshake bundle between decode, the EX compare/shift sequencer and branch-resolve.
// Also carries the shared ALU op encodings used by the sequencer.
`ifndef EX_ALU1_SEQ_DEFINES
`define EX_ALU1_SEQ_DEFINES
`define ALU_BEQ 4'd0
`define ALU_BNE 4'd1
`define ALU_BLT 4'd2
`define ALU_BGE 4'd3
`define ALU_SLT 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`endif

interface ex_alu1_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_signed;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch;
    logic        busy;

    modport master (
        output in_valid, in_op, in_signed, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_result, out_branch, busy
    );

    modport slave (
        input  in_valid, in_op, in_signed, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_result, out_branch, busy
    );
endinterface

// File: rtl/ex_alu1_seq.sv
// EX-stage compare/shift sequencer: compares in 1 cycle, shifts iteratively STEP bits/cycle.
// Latency 1 for compares, 1+ceil(amt/STEP) for shifts; result held in HOLD until out_ready.
module ex_alu1_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input logic          clk,
    input logic          rst,
    ex_alu1_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state;
    logic [XLEN-1:0]   acc;
    logic [4:0]        rem;
    logic [3:0]        sh_op;
    logic [4:0]        n;
    logic [XLEN-1:0]   shifted;
    logic [XLEN:0]     d;
    logic              lt;
    logic              is_shift;
    logic [XLEN-1:0]   cmp_res;
    logic              cmp_br;

    assign bus.in_ready = (state == IDLE) & ~bus.flush;
    assign bus.busy     = (state != IDLE);

    // Signed less-than: unsigned borrow corrected by the operand sign difference.
    always_comb begin
        d        = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        lt       = bus.in_signed ? (d[XLEN] ^ bus.in_a[XLEN-1] ^ bus.in_b[XLEN-1]) : d[XLEN];
        cmp_res  = '0;
        cmp_br   = 1'b0;
        is_shift = 1'b0;
        case (bus.in_op)
            `ALU_BEQ: cmp_br = (d == '0);
            `ALU_BNE: cmp_br = (d != '0);
            `ALU_BLT: cmp_br = lt;
            `ALU_BGE: cmp_br = ~lt;
            `ALU_SLT: cmp_res = {{(XLEN-1){1'b0}}, lt};
            `ALU_SLL, `ALU_SRL, `ALU_SRA: is_shift = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        n       = (rem > 5'(STEP)) ? 5'(STEP) : rem;
        shifted = acc;
        case (sh_op)
            `ALU_SLL: shifted = acc << n;
            `ALU_SRL: shifted = acc >> n;
            default:  shifted = XLEN'($signed(acc) >>> n);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            acc            <= '0;
            rem            <= '0;
            sh_op          <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_branch <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_shift && bus.in_b[4:0] != 5'd0) begin
                            acc   <= bus.in_a;
                            rem   <= bus.in_b[4:0];
                            sh_op <= bus.in_op;
                            state <= SHIFT;
                        end else begin
                            bus.out_result <= is_shift ? bus.in_a : cmp_res;
                            bus.out_branch <= cmp_br;
                            bus.out_valid  <= 1'b1;
                            state          <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shifted;
                    rem <= rem - n;
                    if (rem == n) begin
                        bus.out_result <= shifted;
                        bus.out_branch <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
